// File: rtl/video_pkg.sv
// Shared video definitions: the 24-bit pixel colour type, the colour-bar
// palette, the pattern mode codes and the Wishbone cycle tags used when
// writing pixels to the framebuffer.
package video_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    localparam logic [1:0] MODE_GRID = 2'd0;
    localparam logic [1:0] MODE_BARS = 2'd1;
    localparam logic [1:0] MODE_FLAT = 2'd2;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Colour of bar number idx, left to right across the screen.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = RGB_WHITE;
            3'd1:    bar_colour = RGB_YELLOW;
            3'd2:    bar_colour = RGB_CYAN;
            3'd3:    bar_colour = RGB_GREEN;
            3'd4:    bar_colour = RGB_MAGENTA;
            3'd5:    bar_colour = RGB_RED;
            3'd6:    bar_colour = RGB_BLUE;
            default: bar_colour = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/pattern_gen.sv
// Test-pattern colour generator: purely combinational mapping from the
// current pixel coordinate and the selected mode to a 24-bit RGB value.
// Mode 3 is not a pattern of its own and falls back to the grid.
module pattern_gen
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int YW    = 9
) (
    input  logic [((HDISP > 1) ? $clog2(HDISP) : 1)-1:0] x,
    input  logic [YW-1:0]                                 y,
    input  logic [1:0]                                    mode,
    input  logic [23:0]                                   flat_rgb,
    output rgb_t                                          rgb
);

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [2:0]  bar_idx;
    logic        on_grid;

    // Bars split the line into eight equal slices; the grid draws a white
    // line on every 16th column and every 16th row.
    always_comb begin
        x_ext   = 32'(x);
        y_ext   = 32'(y);
        bar_idx = 3'((x_ext * 32'd8) / 32'(HDISP));
        on_grid = ((x_ext % 32'd16) == 32'd0) || ((y_ext % 32'd16) == 32'd0);
        case (mode)
            MODE_BARS: rgb = bar_colour(bar_idx);
            MODE_FLAT: rgb = flat_rgb;
            default:   rgb = on_grid ? RGB_WHITE : RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/mire_writer.sv
// Test-pattern framebuffer writer: walks every pixel of an HDISP x VDISP
// frame in raster order and writes it to memory over a classic Wishbone
// master port, one beat per pixel, releasing the bus for one cycle after
// every BURST_MAX acknowledged writes so other masters get a turn.
module mire_writer
    import video_pkg::*;
#(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int BURST_MAX = 64
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] flat_rgb,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic        we,
    output logic        stb,
    output logic        cyc,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    output logic        frame_done
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_YIELD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [BW-1:0] burst;
    logic          beat_done;
    logic          burst_full;
    logic          last_pixel;
    rgb_t          pixel_rgb;

    assign beat_done  = (state == ST_WRITE) && ack;
    assign burst_full = (burst == B_LAST);
    assign last_pixel = (x == X_LAST) && (y == Y_LAST);

    pattern_gen #(
        .HDISP (HDISP),
        .YW    (YW)
    ) u_pattern (
        .x        (x),
        .y        (y),
        .mode     (mode),
        .flat_rgb (flat_rgb),
        .rgb      (pixel_rgb)
    );

    // State register; reset abandons any beat in flight.
    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a beat is never cut short, so leaving WRITE only happens
    // on ack, either to yield the bus or because enable has been dropped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ack) begin
                    if (burst_full) begin
                        state_next = ST_YIELD;
                    end else if (!enable) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_YIELD: begin
                state_next = enable ? ST_WRITE : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus outputs: the address and data follow the pixel counters, which only
    // move on ack, so both hold steady for as long as the slave stalls.
    always_comb begin
        cyc    = 1'b0;
        stb    = 1'b0;
        if (state == ST_WRITE) begin
            cyc = 1'b1;
            stb = 1'b1;
        end
        we     = 1'b1;
        sel    = 4'b1111;
        cti    = WB_CTI_CLASSIC;
        bte    = WB_BTE_LINEAR;
        adr    = 32'd4 * ((32'(HDISP) * 32'(y)) + 32'(x));
        dat_ms = {8'h00, pixel_rgb};
    end

    // Raster position: advances one pixel per acknowledged beat and wraps at
    // the end of the line and at the end of the frame.
    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            x <= '0;
            y <= '0;
        end else if (beat_done) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Beats acknowledged in the current tenure; any cycle off the bus starts
    // a fresh tenure.
    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            burst <= '0;
        end else if (state != ST_WRITE) begin
            burst <= '0;
        end else if (ack) begin
            burst <= burst_full ? '0 : burst + 1'b1;
        end
    end

    // One-cycle pulse after the final pixel of the frame is acknowledged.
    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= beat_done && last_pixel;
        end
    end

endmodule

// File: tb/tb_mire_writer.sv
// Self-checking bench for mire_writer: a reduced-height frame keeps whole
// frame runs short while the full line width keeps addresses and bar
// positions identical to the default display.
module tb_mire_writer;

    localparam int HDISP     = 800;
    localparam int VDISP     = 8;
    localparam int BURST_MAX = 64;
    localparam int FRAME_PIX = HDISP * VDISP;

    logic        wshb_clk;
    logic        wshb_rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] flat_rgb;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        frame_done;

    int err_cnt   = 0;
    int chk_cnt   = 0;
    int bench_pix = 0;

    typedef struct {
        int          pix;
        logic [1:0]  mode;
        logic [23:0] flat;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[19];

    mire_writer #(
        .HDISP     (HDISP),
        .VDISP     (VDISP),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .wshb_clk   (wshb_clk),
        .wshb_rst_n (wshb_rst_n),
        .enable     (enable),
        .mode       (mode),
        .flat_rgb   (flat_rgb),
        .adr        (adr),
        .dat_ms     (dat_ms),
        .sel        (sel),
        .we         (we),
        .stb        (stb),
        .cyc        (cyc),
        .cti        (cti),
        .bte        (bte),
        .ack        (ack),
        .frame_done (frame_done)
    );

    initial wshb_clk = 1'b0;
    always #5 wshb_clk = ~wshb_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] md,
                                 input logic [23:0] rgb);
        enable   = en;
        mode     = md;
        flat_rgb = rgb;
    endtask

    task automatic reset_dut();
        @(negedge wshb_clk);
        wshb_rst_n = 1'b0;
        ack        = 1'b0;
        applyStimulus(1'b0, 2'd0, 24'h0);
        repeat (2) @(negedge wshb_clk);
        wshb_rst_n = 1'b1;
        bench_pix  = 0;
    endtask

    // Acknowledge beats until the bus presents pixel 'target'; returns at a
    // negedge with ack low and the target beat waiting.
    task automatic advance_to(input int target, input string name);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge wshb_clk);
            if (cyc && bench_pix == target) begin
                ack     = 1'b0;
                reached = 1'b1;
                break;
            end else if (cyc) begin
                ack       = 1'b1;
                bench_pix = (bench_pix + 1) % FRAME_PIX;
            end else begin
                ack = 1'b0;
            end
        end
        ack = 1'b0;
        checkOutput({name, " reached"}, 32'(reached), 32'd1);
    endtask

    int   beats, tenure, bad_cyc, bad_adr, bad_fd, fd_seen, low_seen;
    logic exp_cyc, exp_fd, next_fd;

    initial begin
        vecs[0]  = '{0,    2'd0, 24'h0,      32'h0000_0000, 32'h00FF_FFFF};
        vecs[1]  = '{1,    2'd0, 24'h0,      32'h0000_0004, 32'h00FF_FFFF};
        vecs[2]  = '{801,  2'd0, 24'h0,      32'h0000_0C84, 32'h0000_0000};
        vecs[3]  = '{816,  2'd0, 24'h0,      32'h0000_0CC0, 32'h00FF_FFFF};
        vecs[4]  = '{817,  2'd0, 24'h0,      32'h0000_0CC4, 32'h0000_0000};
        vecs[5]  = '{899,  2'd1, 24'h0,      32'h0000_0E0C, 32'h00FF_FFFF};
        vecs[6]  = '{900,  2'd1, 24'h0,      32'h0000_0E10, 32'h00FF_FF00};
        vecs[7]  = '{1000, 2'd1, 24'h0,      32'h0000_0FA0, 32'h0000_FFFF};
        vecs[8]  = '{1100, 2'd1, 24'h0,      32'h0000_1130, 32'h0000_FF00};
        vecs[9]  = '{1200, 2'd1, 24'h0,      32'h0000_12C0, 32'h00FF_00FF};
        vecs[10] = '{1300, 2'd1, 24'h0,      32'h0000_1450, 32'h00FF_0000};
        vecs[11] = '{1499, 2'd1, 24'h0,      32'h0000_176C, 32'h0000_00FF};
        vecs[12] = '{1500, 2'd1, 24'h0,      32'h0000_1770, 32'h0000_0000};
        vecs[13] = '{1599, 2'd1, 24'h0,      32'h0000_18FC, 32'h0000_0000};
        vecs[14] = '{1600, 2'd3, 24'h0,      32'h0000_1900, 32'h00FF_FFFF};
        vecs[15] = '{1601, 2'd2, 24'h123456, 32'h0000_1904, 32'h0012_3456};
        vecs[16] = '{1602, 2'd2, 24'hABCDEF, 32'h0000_1908, 32'h00AB_CDEF};
        vecs[17] = '{4817, 2'd0, 24'h0,      32'h0000_4B44, 32'h0000_0000};
        vecs[18] = '{6399, 2'd1, 24'h0,      32'h0000_63FC, 32'h0000_0000};

        wshb_rst_n = 1'b0;
        ack        = 1'b0;
        applyStimulus(1'b0, 2'd0, 24'h0);
        repeat (3) @(negedge wshb_clk);
        #1;
        checkOutput("reset cyc", 32'(cyc), 32'd0);
        checkOutput("reset stb", 32'(stb), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset adr", adr, 32'h0);
        checkOutput("const we", 32'(we), 32'd1);
        checkOutput("const sel", 32'(sel), 32'hF);
        checkOutput("const cti", 32'(cti), 32'd0);
        checkOutput("const bte", 32'(bte), 32'd0);

        wshb_rst_n = 1'b1;
        repeat (3) @(negedge wshb_clk);
        #1;
        checkOutput("idle hold cyc", 32'(cyc), 32'd0);
        applyStimulus(1'b1, 2'd0, 24'h0);
        @(negedge wshb_clk);
        #1;
        checkOutput("write entry cyc", 32'(cyc), 32'd1);
        checkOutput("write entry stb", 32'(stb), 32'd1);
        checkOutput("first adr", adr, 32'h0);
        checkOutput("first dat", dat_ms, 32'h00FF_FFFF);

        $display("[TB] table vectors");
        for (int i = 0; i < 19; i++) begin
            advance_to(vecs[i].pix, $sformatf("vec%0d", i));
            applyStimulus(1'b1, vecs[i].mode, vecs[i].flat);
            #1;
            checkOutput($sformatf("vec%0d adr", i), adr, vecs[i].exp_adr);
            checkOutput($sformatf("vec%0d dat", i), dat_ms, vecs[i].exp_dat);
        end

        $display("[TB] stalled beat on pixel (17,0)");
        reset_dut();
        applyStimulus(1'b1, 2'd0, 24'h0);
        advance_to(17, "stall");
        for (int s = 0; s < 5; s++) begin
            #1;
            checkOutput($sformatf("stall%0d adr", s), adr, 32'h44);
            checkOutput($sformatf("stall%0d dat", s), dat_ms, 32'h00FF_FFFF);
            @(negedge wshb_clk);
        end
        ack = 1'b1;
        #1;
        checkOutput("stall ack-cycle adr", adr, 32'h44);
        @(negedge wshb_clk);
        ack       = 1'b0;
        bench_pix = 18;
        #1;
        checkOutput("stall next adr", adr, 32'h48);

        $display("[TB] enable dropped mid-beat");
        reset_dut();
        applyStimulus(1'b1, 2'd0, 24'h0);
        advance_to(5, "drop");
        enable = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge wshb_clk);
            #1;
            checkOutput($sformatf("drop wait%0d cyc", s), 32'(cyc), 32'd1);
            checkOutput($sformatf("drop wait%0d adr", s), adr, 32'h14);
        end
        ack = 1'b1;
        @(negedge wshb_clk);
        ack       = 1'b0;
        bench_pix = 6;
        #1;
        checkOutput("drop idle cyc", 32'(cyc), 32'd0);
        repeat (3) @(negedge wshb_clk);
        #1;
        checkOutput("drop idle hold cyc", 32'(cyc), 32'd0);
        checkOutput("drop retained adr", adr, 32'h18);
        enable = 1'b1;
        @(negedge wshb_clk);
        #1;
        checkOutput("resume cyc", 32'(cyc), 32'd1);
        checkOutput("resume adr", adr, 32'h18);

        $display("[TB] reset mid-beat");
        advance_to(40, "midreset");
        wshb_rst_n = 1'b0;
        @(negedge wshb_clk);
        #1;
        checkOutput("midreset cyc", 32'(cyc), 32'd0);
        checkOutput("midreset adr", adr, 32'h0);
        wshb_rst_n = 1'b1;
        bench_pix  = 0;
        advance_to(0, "restart");
        #1;
        checkOutput("restart adr", adr, 32'h0);

        $display("[TB] full frame with ack held high");
        reset_dut();
        applyStimulus(1'b1, 2'd0, 24'h0);
        advance_to(0, "frame start");
        ack      = 1'b1;
        beats    = 0;
        tenure   = 0;
        exp_cyc  = 1'b1;
        exp_fd   = 1'b0;
        bad_cyc  = 0;
        bad_adr  = 0;
        bad_fd   = 0;
        fd_seen  = 0;
        low_seen = 0;
        for (int i = 0; i < 8000; i++) begin
            if (i > 0) @(negedge wshb_clk);
            if (cyc !== exp_cyc) bad_cyc++;
            if (frame_done !== exp_fd) bad_fd++;
            if (frame_done) fd_seen++;
            if (!cyc) low_seen++;
            next_fd = 1'b0;
            if (exp_cyc) begin
                if (beats == FRAME_PIX) begin
                    ack = 1'b0;
                    checkOutput("frame wrap adr", adr, 32'h0);
                    break;
                end
                if (adr !== 32'(4 * beats)) bad_adr++;
                beats++;
                tenure++;
                next_fd = (beats == FRAME_PIX);
                if (tenure == BURST_MAX) begin
                    tenure  = 0;
                    exp_cyc = 1'b0;
                end
            end else begin
                exp_cyc = 1'b1;
            end
            exp_fd = next_fd;
        end
        ack = 1'b0;
        checkOutput("frame cyc pattern errors", 32'(bad_cyc), 32'd0);
        checkOutput("frame adr sequence errors", 32'(bad_adr), 32'd0);
        checkOutput("frame_done timing errors", 32'(bad_fd), 32'd0);
        checkOutput("frame_done pulses", 32'(fd_seen), 32'd1);
        checkOutput("yield cycles per frame", 32'(low_seen), 32'd100);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
